// File: rtl/fetch_inst_queue_if.sv
// rtl/fetch_inst_queue_if.sv - fetch-to-decode instruction stream bundle
interface fetch_inst_queue_if #(
  parameter int ADDR = 32,
  parameter int INST = 32
);
  logic            in_valid;
  logic [ADDR-1:0] in_pc;
  logic [INST-1:0] in_inst;
  logic            in_ready;
  logic            out_valid;
  logic [ADDR-1:0] out_pc;
  logic [INST-1:0] out_inst;
  logic            out_ready;

  // master: the fetch producer plus decode consumer around the queue
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  // slave: the queue itself
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - fetch-to-decode instruction queue with single-cycle flush
// Optional zero-latency path through an empty queue: FETCH_INST_QUEUE_BYPASS_EN
module fetch_inst_queue #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       flush,
  fetch_inst_queue_if.slave          q,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR-1:0] pc_mem   [DEPTH];
  logic [INST-1:0] inst_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            empty;
  logic            push;
  logic            pop;

  assign empty      = (count == '0);
  assign q.in_ready = (count != FULL);

`ifdef FETCH_INST_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue forwards fetch straight to decode; a consumed bypass is never stored
  assign bypass      = empty && !flush;
  assign q.out_valid = bypass ? q.in_valid : !empty;
  assign q.out_pc    = bypass ? q.in_pc    : pc_mem[rd_ptr];
  assign q.out_inst  = bypass ? q.in_inst  : inst_mem[rd_ptr];
  assign push        = q.in_valid && q.in_ready && !(bypass && q.out_ready);
  assign pop         = q.out_valid && q.out_ready && !empty;
`else
  assign q.out_valid = !empty;
  assign q.out_pc    = pc_mem[rd_ptr];
  assign q.out_inst  = inst_mem[rd_ptr];
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= q.in_pc;
        inst_mem[wr_ptr] <= q.in_inst;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - directed and randomized bench for fetch_inst_queue
module tb_fetch_inst_queue;
  localparam int ADDR  = 32;
  localparam int INST  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef FETCH_INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_;
  logic          flush;
  logic [CW-1:0] count;

  fetch_inst_queue_if #(.ADDR(ADDR), .INST(INST)) q ();

  fetch_inst_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .flush  (flush),
    .q      (q),
    .count  (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] model [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        bp;
    logic        ev;
    logic [63:0] head;
    bp   = BYP && (model.size() == 0) && !flush;
    ev   = bp ? q.in_valid : (model.size() != 0);
    head = bp ? {q.in_pc, q.in_inst} : ((model.size() != 0) ? model[0] : 64'h0);
    check({tag, ":out_valid"}, 64'(q.out_valid), 64'(ev));
    if (ev) begin
      check({tag, ":out_pc"},   64'(q.out_pc),   64'(head[63:32]));
      check({tag, ":out_inst"}, 64'(q.out_inst), 64'(head[31:0]));
    end
    check({tag, ":in_ready"}, 64'(q.in_ready), 64'(model.size() < DEPTH));
    check({tag, ":count"},    64'(count),      64'(model.size()));
  endtask

  task automatic model_edge(input logic fl, input logic iv, input logic [63:0] ent, input logic ordy);
    int n;
    n = model.size();
    if (fl) begin
      model.delete();
    end else if (!(BYP && n == 0 && iv && ordy)) begin
      if (n > 0 && ordy) void'(model.pop_front());
      if (iv && n < DEPTH) model.push_back(ent);
    end
  endtask

  // Inputs driven at posedge+1, outputs checked at posedge+3
  task automatic step(input string tag, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    flush      = fl;
    q.in_valid = iv;
    q.in_pc    = pc;
    q.in_inst  = inst;
    q.out_ready = ordy;
    #2;
    check_outputs(tag);
    @(posedge clk);
    model_edge(fl, iv, {pc, inst}, ordy);
    #1;
  endtask

  initial begin
    reset_      = 1'b0;
    flush       = 1'b0;
    q.in_valid  = 1'b0;
    q.in_pc     = '0;
    q.in_inst   = '0;
    q.out_ready = 1'b0;
    #2;
    check_outputs("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;

    step("pre_push0", 1'b0, 1'b1, 32'h80, ~32'h80, 1'b0);
    step("pre_push1", 1'b0, 1'b1, 32'h84, ~32'h84, 1'b0);
    q.in_valid = 1'b1;
    q.in_pc    = 32'h88;
    q.in_inst  = ~32'h88;
    #2;
    reset_ = 1'b0;
    #1;
    model.delete();
    check_outputs("rst_mid");
    @(posedge clk);
    #2;
    check_outputs("rst_hold");
    q.in_valid = 1'b0;
    reset_     = 1'b1;
    #1;
    check_outputs("rst_release");
    @(posedge clk);
    #1;
    step("rst_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int k = 0; k < 4; k++)
      step("fill", 1'b0, 1'b1, 32'h100 + 32'(4 * k), ~(32'h100 + 32'(4 * k)), 1'b0);
    step("fill_reject", 1'b0, 1'b1, 32'h110, ~32'h110, 1'b0);
    for (int k = 0; k < 4; k++)
      step("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step("drained", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    for (int k = 0; k < 10; k++)
      step("wrap", 1'b0, 1'b1, 32'h200 + 32'(4 * k), ~(32'h200 + 32'(4 * k)), k >= 2);
    step("wrap_drain0", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step("wrap_drain1", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    for (int k = 0; k < 4; k++)
      step("full_fill", 1'b0, 1'b1, 32'h300 + 32'(4 * k), ~(32'h300 + 32'(4 * k)), 1'b0);
    step("full_pushpop", 1'b0, 1'b1, 32'h310, ~32'h310, 1'b1);
    step("after_full", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    step("flush", 1'b1, 1'b1, 32'h320, ~32'h320, 1'b1);
    step("post_flush", 1'b0, 1'b1, 32'h400, ~32'h400, 1'b0);
    step("flush_head", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step("flush_empty", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    step("bypass", 1'b0, 1'b1, 32'h500, ~32'h500, 1'b1);
    step("bypass_next", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step("bypass_idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    for (int k = 0; k < 400; k++) begin
      logic        fl;
      logic        iv;
      logic        ordy;
      logic [31:0] pc;
      logic [31:0] inst;
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = $urandom_range(0, 1) == 1;
      pc   = $urandom & 32'hffff_fffc;
      inst = $urandom;
      step("random", fl, iv, pc, inst, ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Instruction queue between the fetch stage and the decoder.
- Accepts {pc, inst} pairs from fetch_top's decode-side output, buffers up to DEPTH entries, and presents them in order to the decode stage.
- Absorbs decode stalls without back-pressuring the I-cache path.
- Supports a single-cycle flush on redirect, such as a branch mispredict or exception.

Parameters:
ADDR, 32, PC width in bits (matches AddrWidth)
INST, 32, instruction width in bits (matches InstWidth)
DEPTH, 4, number of entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_  input  1  asynchronous active-low reset
flush  input  1  discard all entries this cycle
in_valid  input  1  fetch presents a valid {pc, inst}
in_pc  input  ADDR  PC of incoming instruction
in_inst  input  INST  incoming instruction word
in_ready  output  1  queue can accept an entry this cycle
out_valid  output  1  head entry valid toward decode
out_pc  output  ADDR  PC of head entry
out_inst  output  INST  head instruction word
out_ready  input  1  decode consumes head this cycle
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Reset: one clock (clk); reset_ is asynchronous, active-low. Asserting reset_ low clears state immediately, regardless of clk:
  - rd_ptr=0, wr_ptr=0, count=0
  - out_valid=0, in_ready=1
  - out_pc and out_inst are don't-care while out_valid=0; they reset to 0.
- Storage:
  - DEPTH-entry circular buffer.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register, not derived from the pointers, which disambiguates full from empty.
- Push: in_valid && in_ready. Writes entry[wr_ptr] and increments wr_ptr.
- Pop: out_valid && out_ready. Increments rd_ptr.
- Occupancy update:
  - count += push − pop.
  - Simultaneous push and pop leave count unchanged, including when full: in_ready=0 when full, so no push is possible.
  - Simultaneous push and pop when count=1 are legal; the new entry becomes head next cycle.
- Handshake outputs:
  - in_ready = (count != DEPTH). It does not depend combinationally on out_ready; no full-with-pop pass-through.
  - out_valid = (count != 0).
  - out_pc and out_inst = entry[rd_ptr].
- Latency: an entry pushed at edge N is visible on out_* after edge N, so it can pop at edge N+1 (1-cycle latency). Feature off.
- Ordering: strict FIFO. Entries are never dropped or duplicated except by flush or reset.
- Flush (synchronous, highest priority):
  - On the edge with flush=1: rd_ptr=wr_ptr=0 and count=0.
  - Any push or pop in that cycle is ignored.
  - Next cycle: out_valid=0, in_ready=1.
  - Flush with the queue empty is a no-op apart from the pointer reset.
- Illegal input: in_valid=1 while in_ready=0 is not an error. The entry is not accepted, and fetch holds it.
- Input stability: in_pc and in_inst are sampled only on a push. No stability requirement otherwise.
- Reset mid-operation: reset_ low during any traffic aborts immediately to the reset state. No partial write survives.

Optional Feature:
FETCH_INST_QUEUE_BYPASS_EN
- Defined, bypass applies only when count=0 and flush=0:
  - out_valid = in_valid, out_pc = in_pc, out_inst = in_inst, combinationally.
  - If out_ready=1 in that cycle, the entry goes straight to decode and is not written; count stays 0.
  - If out_ready=0, the entry is pushed normally.
  - Result: zero-cycle latency through an empty queue.
  - in_ready is unchanged; it is still 1 when empty.
- Not defined: no combinational path from the in_* ports to the out_* ports. Latency is exactly 1 cycle as above.

Test Plan:
1. Reset: hold reset_=0 mid-clock with in_valid=1 -> out_valid=0, in_ready=1, count=0 immediately; still so after reset_ rises until the first push.
2. Fill/drain: out_ready=0; push pc 0x100, 0x104, 0x108, 0x10C -> count=4, in_ready=0; fifth in_valid ignored. Then out_ready=1 -> pops 0x100..0x10C in order over 4 cycles, then out_valid=0.
3. Wrap-around: 10 pushes and pops interleaved at count≈2 (pc 0x200+4k) -> pointers wrap; outputs in exact order; count never exceeds 3.
4. Simultaneous push/pop at full: count=4, out_ready=1, in_valid=1 -> pop occurs, push rejected (in_ready=0); next cycle count=3, in_ready=1.
5. Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the next push of pc 0x400 appears as head.
6. Bypass (macro defined): empty queue, in_valid=1, pc 0x500, out_ready=1 -> out_valid=1 and out_pc=0x500 the same cycle; count stays 0. Without the macro -> out_valid rises the next cycle.
